dice_roll_sequencer: RTL and testbench
======================================

// Module: dice_roll_sequencer
// PURPOSE
//  Roll controller between the per-button debouncers and the result display.
//  - Generates the shared debounce tick.
//  - Arbitrates die-select presses across 6 debounced buttons (d4,d6,d8,d10,d12,d20).
//  - Sequences a roll: hold, spin, reduce, show.
//  - Reduces a free-running LFSR value to 1..sides by iterative subtraction.
// PARAMETERS
//  TICK_DIV    16       clk cycles per tick_out pulse (>=2)
//  SPIN_TICKS  8        ticks spent in SPIN after release (>=1)
//  LFSR_SEED   16'hACE1 LFSR reset value (must be nonzero)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  synchronous active-low reset
//  btn_db        in   6  debounced button levels; bit i = die i (sides 4,6,8,10,12,20)
//  tick_out      out  1  one-clk pulse every TICK_DIV clks; feeds debouncers
//  sel_die       out  3  index of die being rolled or shown (0..5)
//  rolling       out  1  high in HELD, SPIN, REDUCE
//  result        out  5  roll value 1..20; 0 when no result held
//  result_valid  out  1  high only in SHOW
// BEHAVIOUR
//  Reset: clock and reset are fixed as above; all state updates at posedge clk only.
//   - rst_n low at any edge, including mid-roll, forces next-cycle values:
//     state=IDLE, tick_out=0, tick counter=0, sel_die=0, rolling=0, result=0,
//     result_valid=0, btn_q=0, lfsr=LFSR_SEED.
//  Tick: counter runs 0..TICK_DIV-1 and wraps; tick_out=1 for the clk where counter==TICK_DIV-1.
//  LFSR: 16-bit Galois, mask 16'hB400.
//   - Shifts right every clk outside reset.
//   - Feedback taken from lsb.
//  Edge detect:
//   - btn_q <= btn_db every clk.
//   - rise = btn_db & ~btn_q.
//  Arbitration: among set rise bits, lowest index wins.
//   - Presses are accepted only in IDLE and SHOW.
//   - All rises in other states are ignored, not queued.
//  FSM:
//   - IDLE: any rise -> HELD; sel_die <= winner.
//   - HELD: LFSR keeps spinning.
//     - btn_db[sel_die]==0 -> SPIN; spin count <= 0.
//     - Other buttons ignored.
//   - SPIN: count increments on tick_out.
//     - On the tick where count==SPIN_TICKS-1 -> REDUCE; r <= lfsr[7:0].
//   - REDUCE: one step per clk.
//     - If r >= sides[sel_die], r <= r - sides.
//     - Else result <= r+1 and -> SHOW.
//     - Worst case 64 clks (d4, r=255).
//   - SHOW: result_valid=1; result and sel_die hold.
//     - Any rise -> HELD, same clk rules as IDLE.
//     - result_valid=0 and result=0 from the next cycle.
//  Widths:
//   - r is 8 bits.
//   - Subtraction never underflows (guarded by compare).
//   - result = r+1 truncated to 5 bits; max value 20.
//  Simultaneous events:
//   - Press and release of the same button in one clk is not possible (levels).
//   - Two rises in one clk: lowest index wins.
//   - tick_out coinciding with the REDUCE entry edge: no effect.
// CONFIGURATION
//  SHOW_TIMEOUT_EN defined:
//   - SHOW counts tick_out pulses.
//   - After 256 ticks with no rise -> IDLE; result=0, result_valid=0.
//   - A rise in the same clk as the timeout wins: -> HELD.
//  SHOW_TIMEOUT_EN undefined: SHOW persists until the next rise; no timeout counter is built.
// TESTING
//  1. Reset, TICK_DIV=16 -> tick_out first high at cycle 15 after reset release, then every 16; result=0, result_valid=0.
//  2. Pulse btn_db[5] (d20) high 40 clks, release -> rolling=1 through HELD/SPIN(8 ticks)/REDUCE, then result_valid=1, result in 1..20, sel_die=5; matches a model LFSR.
//  3. btn_db[1] and btn_db[4] rise in same clk -> sel_die=1 (d6); result in 1..6.
//  4. During SPIN, raise btn_db[0] -> ignored; sel_die unchanged; after SHOW, a fresh rise of btn_db[0] -> new roll, result_valid=0 next clk.
//  5. Force lfsr[7:0]=255 at REDUCE entry with d4 -> 64 REDUCE clks, result=4.
//  6. Assert rst_n low mid-REDUCE -> next clk all outputs at reset values; with SHOW_TIMEOUT_EN, idle SHOW for 256 ticks -> result_valid=0.

Source files
------------

// File: rtl/dice_roll_sequencer.sv
// +--------------------------------------------------------------------------+
// | dice_roll_sequencer: debounce tick, die-select arbitration, roll FSM and |
// | LFSR-to-die reduction. Optional SHOW timeout via `define SHOW_TIMEOUT_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dice_roll_sequencer #(
  parameter int unsigned TICK_DIV   = 16,
  parameter int unsigned SPIN_TICKS = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_db,
  output logic       tick_out,
  output logic [2:0] sel_die,
  output logic       rolling,
  output logic [4:0] result,
  output logic       result_valid
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SPIN_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPIN_LAST = SW'(SPIN_TICKS - 1);
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HELD   = 3'd1;
  localparam logic [2:0] S_SPIN   = 3'd2;
  localparam logic [2:0] S_REDUCE = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [5:0]    btn_q;
  logic [2:0]    sel_q, sel_d;
  logic [SW-1:0] spin_q, spin_d;
  logic [7:0]    r_q, r_d;
  logic [4:0]    result_q, result_d;
`ifdef SHOW_TIMEOUT_EN
  logic [7:0]    show_cnt_q, show_cnt_d;
`endif

  logic       w_tick;
  logic [5:0] w_rise;
  logic       w_any_rise;
  logic [2:0] w_win;
  logic [7:0] w_sides;
  logic       w_sel_lvl;

  assign w_tick     = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
  assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  assign w_rise     = btn_db & ~btn_q;
  assign w_any_rise = |w_rise;
  assign w_sel_lvl  = |(btn_db & (6'd1 << sel_q));

  // Lowest-index rising button wins.
  always_comb begin
    w_win = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_rise[i]) w_win = 3'(i);
    end
  end

  always_comb begin
    case (sel_q)
      3'd0:    w_sides = 8'd4;
      3'd1:    w_sides = 8'd6;
      3'd2:    w_sides = 8'd8;
      3'd3:    w_sides = 8'd10;
      3'd4:    w_sides = 8'd12;
      default: w_sides = 8'd20;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    spin_d   = spin_q;
    r_d      = r_q;
    result_d = result_q;
`ifdef SHOW_TIMEOUT_EN
    show_cnt_d = show_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_any_rise) begin
          state_d = S_HELD;
          sel_d   = w_win;
        end
      end
      S_HELD: begin
        if (!w_sel_lvl) begin
          state_d = S_SPIN;
          spin_d  = '0;
        end
      end
      S_SPIN: begin
        if (w_tick) begin
          if (spin_q == SPIN_LAST) begin
            state_d = S_REDUCE;
            r_d     = lfsr_q[7:0];
          end else begin
            spin_d = spin_q + 1'b1;
          end
        end
      end
      S_REDUCE: begin
        // r < sides <= 20 here, so the low five bits carry the whole value.
        if (r_q >= w_sides) begin
          r_d = r_q - w_sides;
        end else begin
          result_d = r_q[4:0] + 5'd1;
          state_d  = S_SHOW;
`ifdef SHOW_TIMEOUT_EN
          show_cnt_d = '0;
`endif
        end
      end
      S_SHOW: begin
        if (w_any_rise) begin
          state_d  = S_HELD;
          sel_d    = w_win;
          result_d = '0;
        end
`ifdef SHOW_TIMEOUT_EN
        else if (w_tick) begin
          if (show_cnt_q == 8'hFF) begin
            state_d  = S_IDLE;
            result_d = '0;
          end else begin
            show_cnt_d = show_cnt_q + 8'd1;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      btn_q      <= '0;
      sel_q      <= '0;
      spin_q     <= '0;
      r_q        <= '0;
      result_q   <= '0;
`ifdef SHOW_TIMEOUT_EN
      show_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_db;
      sel_q      <= sel_d;
      spin_q     <= spin_d;
      r_q        <= r_d;
      result_q   <= result_d;
`ifdef SHOW_TIMEOUT_EN
      show_cnt_q <= show_cnt_d;
`endif
    end
  end

  assign tick_out     = w_tick;
  assign sel_die      = sel_q;
  assign result       = result_q;
  assign rolling      = (state_q == S_HELD) || (state_q == S_SPIN) || (state_q == S_REDUCE);
  assign result_valid = (state_q == S_SHOW);

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_dice_roll_sequencer: randomized rolls against a cycle-indexed model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dice_roll_sequencer;

  localparam int          TICK_DIV   = 16;
  localparam int          SPIN_TICKS = 8;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          TABN       = 70000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn_db = 6'd0;
  logic       tick_out;
  logic [2:0] sel_die;
  logic       rolling;
  logic [4:0] result;
  logic       result_valid;

  dice_roll_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .SPIN_TICKS(SPIN_TICKS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_db      (btn_db),
    .tick_out    (tick_out),
    .sel_die     (sel_die),
    .rolling     (rolling),
    .result      (result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] tab [TABN];
  logic        prev_valid;
  logic [4:0]  prev_result;
  logic [2:0]  prev_sel;
  int          show_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic advance();
    logic was_rst;
    was_rst = !rst_n;
    @(posedge clk);
    #1;
    if (was_rst) cyc = 0;
    else cyc++;
    if (cyc >= TABN) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d want=<%0d", cyc, cyc, TABN);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic chk_all(input logic er, input logic ev, input logic [4:0] eres, input logic [2:0] esel);
    chk("tick", 32'(tick_out), 32'((cyc % TICK_DIV) == (TICK_DIV - 1)));
    chk("rolling", 32'(rolling), 32'(er));
    chk("valid", 32'(result_valid), 32'(ev));
    chk("result", 32'(result), 32'(eres));
    chk("sel", 32'(sel_die), 32'(esel));
  endtask

  function automatic int first_tick(input int s);
    return s + (TICK_DIV - 1 - (s % TICK_DIV));
  endfunction

  function automatic int die_sides(input logic [2:0] d);
    case (d)
      3'd0:    return 4;
      3'd1:    return 6;
      3'd2:    return 8;
      3'd3:    return 10;
      3'd4:    return 12;
      default: return 20;
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk_all(1'b0, prev_valid, prev_result, prev_sel);
      btn_db = 6'd0;
      advance();
    end
  endtask

  // One roll: press mask now, release after 'hold' clks; expectations come from
  // the spin/reduce timing rules applied to the model LFSR table.
  task automatic run_roll(input logic [5:0] mask, input int hold, input bit ign,
                          input int wait_show, input bit stop_in_reduce);
    int p, s, t, k, re, last, sides;
    logic [7:0] r;
    logic [2:0] win;
    logic [4:0] res;
    win = 3'd0;
    for (int i = 5; i >= 0; i--) if (mask[i]) win = 3'(i);
    sides = die_sides(win);
    p = cyc;
    s = p + hold + 1;
    t = first_tick(s) + (SPIN_TICKS - 1) * TICK_DIV;
    if (t >= TABN) begin
      $display("FAIL roll_window cyc=%0d got=%0d want=<%0d", cyc, t, TABN);
      $fatal(1, "roll beyond model table");
    end
    r = tab[t][7:0];
    k = int'(r) / sides;
    re = t + 1 + k;
    res = 5'((int'(r) % sides) + 1);
    show_start = re + 1;
    last = stop_in_reduce ? t + 1 : re + wait_show;
    while (cyc <= last) begin
      if (cyc == p) chk_all(1'b0, prev_valid, prev_result, prev_sel);
      else if (cyc <= re) chk_all(1'b1, 1'b0, 5'd0, win);
      else chk_all(1'b0, 1'b1, res, win);
      if (cyc < p + hold) btn_db = mask;
      else if (ign && cyc >= s + 5 && cyc <= re) btn_db = 6'b000001;
      else btn_db = 6'd0;
      if (stop_in_reduce && cyc == last) break;
      advance();
    end
    if (!stop_in_reduce) begin
      prev_valid  = 1'b1;
      prev_result = res;
      prev_sel    = win;
    end
  endtask

  initial begin
    int t, p;
    bit found;
    logic [5:0] m;

    tab[0] = SEED;
    for (int i = 1; i < TABN; i++)
      tab[i] = {1'b0, tab[i-1][15:1]} ^ (tab[i-1][0] ? 16'hB400 : 16'h0000);

    prev_valid = 1'b0;
    prev_result = 5'd0;
    prev_sel = 3'd0;

    rst_n = 1'b0;
    repeat (3) advance();
    rst_n = 1'b1;
    idle_cycles(40);

    // d4 with r=255 at REDUCE entry: release timed so the 8th spin tick lands there.
    found = 1'b0;
    for (t = first_tick(cyc + 140); t < TABN - 200; t += TICK_DIV) begin
      if (tab[t][7:0] == 8'hFF) begin
        found = 1'b1;
        break;
      end
    end
    chk("lfsr255_reachable", 32'(found), 32'd1);
    if (found) begin
      p = t - (SPIN_TICKS - 1) * TICK_DIV - 8 - 2;
      idle_cycles(p - cyc);
      run_roll(6'b000001, 1, 1'b0, 3, 1'b0);
      chk("d4_r255_result", 32'(result), 32'd4);
    end

    run_roll(6'b100000, 40, 1'b0, 5, 1'b0);
    chk("d20_sel", 32'(sel_die), 32'd5);

    run_roll(6'b010010, 7, 1'b0, 4, 1'b0);
    chk("d6_sel", 32'(sel_die), 32'd1);
    chk("d6_range", 32'(result >= 5'd1 && result <= 5'd6), 32'd1);

    run_roll(6'b001000, 10, 1'b1, 3, 1'b0);
    run_roll(6'b000001, 5, 1'b0, 2, 1'b0);

    for (int n = 0; n < 16; n++) begin
      m = 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) m = m | 6'($urandom);
      run_roll(m, int'($urandom_range(1, 40)), ($urandom_range(0, 4) == 0),
               int'($urandom_range(1, 30)), 1'b0);
    end

`ifdef SHOW_TIMEOUT_EN
    begin
      int u;
      u = first_tick(show_start) + 255 * TICK_DIV;
      while (cyc <= u + 3) begin
        if (cyc <= u) chk_all(1'b0, 1'b1, prev_result, prev_sel);
        else chk_all(1'b0, 1'b0, 5'd0, prev_sel);
        btn_db = 6'd0;
        advance();
      end
      prev_valid = 1'b0;
      prev_result = 5'd0;
    end
`endif

    // Reset asserted in the first REDUCE clock.
    run_roll(6'b000100, 3, 1'b0, 0, 1'b1);
    rst_n = 1'b0;
    btn_db = 6'd0;
    advance();
    chk_all(1'b0, 1'b0, 5'd0, 3'd0);
    rst_n = 1'b1;
    prev_valid = 1'b0;
    prev_result = 5'd0;
    prev_sel = 3'd0;
    idle_cycles(20);
    run_roll(6'b000010, 2, 1'b0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
